// File: rtl/clock_mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl_pkg
// Brief    : Shared state encodings, field codes and blink masks for the
//            clock/alarm user-interface controller.
// Revision : 1.0
// ============================================================================
package clock_mode_ctrl_pkg;

    localparam logic [2:0] ST_RUN         = 3'd0;
    localparam logic [2:0] ST_SET_HOUR    = 3'd1;
    localparam logic [2:0] ST_SET_MIN     = 3'd2;
    localparam logic [2:0] ST_SET_AL_HOUR = 3'd3;
    localparam logic [2:0] ST_SET_AL_MIN  = 3'd4;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    localparam logic [5:0] BLINK_NONE = 6'b000000;
    localparam logic [5:0] BLINK_HOUR = 6'b000011;
    localparam logic [5:0] BLINK_MIN  = 6'b001100;

    // Mode-button sequence: RUN -> time h/m -> alarm h/m -> RUN
    function automatic logic [2:0] next_mode_state(input logic [2:0] st);
        case (st)
            ST_RUN:         return ST_SET_HOUR;
            ST_SET_HOUR:    return ST_SET_MIN;
            ST_SET_MIN:     return ST_SET_AL_HOUR;
            ST_SET_AL_HOUR: return ST_SET_AL_MIN;
            default:        return ST_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl_if
// Brief    : Button/tick inputs and datapath/display controls of the clock
//            user-interface controller.
// Revision : 1.0
// ============================================================================
interface clock_mode_ctrl_if;

    logic       tick_1s;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       alarm_match;
    logic [1:0] field_sel;
    logic       tgt_alarm;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       show_alarm;
    logic [5:0] blink_mask;
    logic       alarm_armed;
    logic       ring;

    modport master (
        input  tick_1s, btn_mode, btn_up, btn_down, alarm_match,
        output field_sel, tgt_alarm, inc_pulse, dec_pulse, show_alarm,
               blink_mask, alarm_armed, ring
    );

    modport slave (
        output tick_1s, btn_mode, btn_up, btn_down, alarm_match,
        input  field_sel, tgt_alarm, inc_pulse, dec_pulse, show_alarm,
               blink_mask, alarm_armed, ring
    );

endinterface
`default_nettype wire

// File: rtl/clock_mode_ctrl_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl_btn_conditioner
// Brief    : Synchronizer, debouncer, press-event detector and optional
//            auto-repeat for one raw push button.
// Revision : 1.0
// ============================================================================
module clock_mode_ctrl_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_allow,
    output logic press
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]        r_sync;
    logic              r_level;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_press;
    logic              w_rise;
    logic              w_repeat;

    // Reset treats the button as already held, so a button that is down
    // through reset must be released and pressed again to register.
    always_ff @(posedge clk) begin
        if (!rst) r_sync <= 2'b11;
        else      r_sync <= {r_sync[0], btn_raw};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_level  <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_sync[1] == r_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_level  <= r_sync[1];
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_rise = r_sync[1] && !r_level && (r_db_cnt == c_DB_LAST);

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int c_RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int c_RP_W   = $clog2(c_RP_MAX + 1);
            localparam logic [c_RP_W-1:0] c_DELAY_LAST  = c_RP_W'(REPEAT_DELAY - 1);
            localparam logic [c_RP_W-1:0] c_PERIOD_LAST = c_RP_W'(REPEAT_PERIOD - 1);

            logic [c_RP_W-1:0] r_rep_cnt;
            logic              r_rep_on;
            logic              r_rep_phase;
            logic [c_RP_W-1:0] w_target;

            // First repeat waits the long delay, later ones the short period
            assign w_target = r_rep_phase ? c_PERIOD_LAST : c_DELAY_LAST;
            assign w_repeat = r_rep_on && r_level && repeat_allow && (r_rep_cnt == w_target);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rep_cnt   <= '0;
                    r_rep_on    <= 1'b0;
                    r_rep_phase <= 1'b0;
                end else if (w_rise) begin
                    r_rep_cnt   <= '0;
                    r_rep_on    <= 1'b1;
                    r_rep_phase <= 1'b0;
                end else if (!r_level || !repeat_allow) begin
                    r_rep_cnt   <= '0;
                    r_rep_on    <= 1'b0;
                    r_rep_phase <= 1'b0;
                end else if (r_rep_on) begin
                    if (r_rep_cnt == w_target) begin
                        r_rep_cnt   <= '0;
                        r_rep_phase <= 1'b1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end
            end
        end else begin : g_no_repeat
            logic w_unused_allow;
            assign w_unused_allow = repeat_allow;
            assign w_repeat       = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) r_press <= 1'b0;
        else      r_press <= w_rise | w_repeat;
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl
// Brief    : Clock/alarm UI controller: button handling, set-mode sequencing,
//            inc/dec strobes, alarm arming, ringing, snooze and display blink.
// Revision : 1.0
// ============================================================================
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int IDLE_TIMEOUT    = 30,
    parameter int RING_TIMEOUT    = 60,
    parameter int SNOOZE_TICKS    = 300
) (
    input  logic              clk,
    input  logic              rst,
    clock_mode_ctrl_if.master bus
);

    localparam int c_IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int c_RING_W = $clog2(RING_TIMEOUT + 1);
    localparam int c_SNZ_W  = $clog2(SNOOZE_TICKS + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [c_RING_W-1:0] c_RING_LAST = c_RING_W'(RING_TIMEOUT - 1);
    localparam logic [c_SNZ_W-1:0]  c_SNZ_LAST  = c_SNZ_W'(SNOOZE_TICKS - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [c_RING_W-1:0] r_ring_cnt;
    logic [c_SNZ_W-1:0]  r_snz_cnt;
    logic                r_snz_on;
    logic                r_ring;
    logic                r_armed;
    logic                r_blink;
    logic                r_match_d;
    logic                r_inc;
    logic                r_dec;

    logic       w_mode_evt, w_up_evt, w_dn_evt;
    logic       w_in_set, w_any_evt, w_up_act, w_dn_act;
    logic       w_idle_hit, w_toggle_arm, w_disarm, w_enter_al, w_match_rise;
    logic [1:0] w_field_sel;
    logic       w_alarm_view;
    logic [5:0] w_blink_mask;

    clock_mode_ctrl_btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b0)
    ) u_btn_mode (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (bus.btn_mode),
        .repeat_allow (1'b0),
        .press        (w_mode_evt)
    );

    clock_mode_ctrl_btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b1)
    ) u_btn_up (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (bus.btn_up),
        .repeat_allow (w_in_set),
        .press        (w_up_evt)
    );

    clock_mode_ctrl_btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b1)
    ) u_btn_down (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (bus.btn_down),
        .repeat_allow (w_in_set),
        .press        (w_dn_evt)
    );

    // Mode outranks up/down; up and down together cancel each other
    assign w_in_set     = (r_state != ST_RUN);
    assign w_any_evt    = w_mode_evt | w_up_evt | w_dn_evt;
    assign w_up_act     = w_up_evt & ~w_dn_evt & ~w_mode_evt;
    assign w_dn_act     = w_dn_evt & ~w_up_evt & ~w_mode_evt;
    assign w_idle_hit   = w_in_set && bus.tick_1s && !w_any_evt && (r_idle_cnt == c_IDLE_LAST);
    assign w_toggle_arm = !w_in_set && !r_ring && w_up_act;
    assign w_disarm     = w_toggle_arm && r_armed;
    assign w_enter_al   = !r_ring && w_mode_evt && (r_state == ST_SET_MIN);
    assign w_match_rise = bus.alarm_match & ~r_match_d;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_next_state;
    end

    // While ringing, button presses only silence the buzzer
    always_comb begin
        w_next_state = r_state;
        if (!r_ring && w_mode_evt) begin
            w_next_state = next_mode_state(r_state);
        end else if (w_idle_hit) begin
            w_next_state = ST_RUN;
        end
    end

    always_comb begin
        w_field_sel  = FIELD_NONE;
        w_alarm_view = 1'b0;
        w_blink_mask = BLINK_NONE;
        case (r_state)
            ST_SET_HOUR: begin
                w_field_sel  = FIELD_HOUR;
                w_blink_mask = r_blink ? BLINK_HOUR : BLINK_NONE;
            end
            ST_SET_MIN: begin
                w_field_sel  = FIELD_MIN;
                w_blink_mask = r_blink ? BLINK_MIN : BLINK_NONE;
            end
            ST_SET_AL_HOUR: begin
                w_field_sel  = FIELD_HOUR;
                w_alarm_view = 1'b1;
                w_blink_mask = r_blink ? BLINK_HOUR : BLINK_NONE;
            end
            ST_SET_AL_MIN: begin
                w_field_sel  = FIELD_MIN;
                w_alarm_view = 1'b1;
                w_blink_mask = r_blink ? BLINK_MIN : BLINK_NONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
        end else begin
            r_inc <= w_in_set && !r_ring && w_up_act;
            r_dec <= w_in_set && !r_ring && w_dn_act;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idle_cnt <= '0;
        end else if (!w_in_set || w_any_evt) begin
            r_idle_cnt <= '0;
        end else if (bus.tick_1s) begin
            r_idle_cnt <= w_idle_hit ? '0 : r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_armed   <= 1'b0;
            r_blink   <= 1'b0;
            r_match_d <= 1'b0;
        end else begin
            r_blink   <= r_blink ^ bus.tick_1s;
            r_match_d <= bus.alarm_match;
            if (w_toggle_arm)    r_armed <= ~r_armed;
            else if (w_enter_al) r_armed <= 1'b1;
        end
    end

    // Ring / snooze sequencer; disarming always wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
            r_snz_on   <= 1'b0;
            r_snz_cnt  <= '0;
        end else if (w_disarm) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
            r_snz_on   <= 1'b0;
            r_snz_cnt  <= '0;
        end else if (r_ring) begin
            if (w_mode_evt || w_up_act) begin
                r_ring     <= 1'b0;
                r_ring_cnt <= '0;
            end else if (w_dn_act) begin
                r_ring     <= 1'b0;
                r_ring_cnt <= '0;
                r_snz_on   <= 1'b1;
                r_snz_cnt  <= '0;
            end else if (bus.tick_1s) begin
                if (r_ring_cnt == c_RING_LAST) begin
                    r_ring     <= 1'b0;
                    r_ring_cnt <= '0;
                end else begin
                    r_ring_cnt <= r_ring_cnt + 1'b1;
                end
            end
        end else if (r_armed && w_match_rise) begin
            r_ring     <= 1'b1;
            r_ring_cnt <= '0;
            r_snz_on   <= 1'b0;
            r_snz_cnt  <= '0;
        end else if (r_snz_on && bus.tick_1s) begin
            if (r_snz_cnt == c_SNZ_LAST) begin
                r_ring     <= 1'b1;
                r_ring_cnt <= '0;
                r_snz_on   <= 1'b0;
                r_snz_cnt  <= '0;
            end else begin
                r_snz_cnt <= r_snz_cnt + 1'b1;
            end
        end
    end

    assign bus.field_sel   = w_field_sel;
    assign bus.tgt_alarm   = w_alarm_view;
    assign bus.show_alarm  = w_alarm_view;
    assign bus.blink_mask  = w_blink_mask;
    assign bus.inc_pulse   = r_inc;
    assign bus.dec_pulse   = r_dec;
    assign bus.alarm_armed = r_armed;
    assign bus.ring        = r_ring;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_mode_ctrl
// Brief    : Directed and randomized bench for clock_mode_ctrl with a
//            behavioural model of the user-interface rules.
// Revision : 1.0
// ============================================================================
module tb_clock_mode_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int IT = 3;
    localparam int RT = 4;
    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       match;
    logic [2:0] btn;   // 0 mode, 1 up, 2 down

    always #5 clk = ~clk;

    clock_mode_ctrl_if bus();
    assign bus.tick_1s     = tick;
    assign bus.btn_mode    = btn[0];
    assign bus.btn_up      = btn[1];
    assign bus.btn_down    = btn[2];
    assign bus.alarm_match = match;

    clock_mode_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .IDLE_TIMEOUT    (IT),
        .RING_TIMEOUT    (RT),
        .SNOOZE_TICKS    (ST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_inc = 0;
    int n_dec = 0;
    int hold_left [3];

    // Model: buttons as sample pipeline + stable-run counter, mode as index 0..4
    logic m_s1 [3], m_s2 [3], m_lvl [3], m_evt [3], m_rep_on [3];
    int   m_run [3], m_next_rep [3];
    int   m_cyc = 0;
    int   m_idx = 0, m_idle = 0, m_ring_t = 0, m_snz_t = 0;
    logic m_armed = 0, m_ring = 0, m_snz_on = 0, m_phase = 0, m_mprev = 0, m_inc = 0, m_dec = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic me, ue, de, any, up_act, dn_act, rise, n_armed, allow, samp, fire;
        int   old_idx, n_idx, n_idle;
        m_cyc++;
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 1; m_s2[b] = 1; m_lvl[b] = 1; m_evt[b] = 0;
                m_rep_on[b] = 0; m_run[b] = 0; m_next_rep[b] = 0;
            end
            m_idx = 0; m_idle = 0; m_ring_t = 0; m_snz_t = 0;
            m_armed = 0; m_ring = 0; m_snz_on = 0; m_phase = 0; m_mprev = 0; m_inc = 0; m_dec = 0;
            return;
        end
        me = m_evt[0]; ue = m_evt[1]; de = m_evt[2];
        any    = me | ue | de;
        up_act = ue && !de && !me;
        dn_act = de && !ue && !me;
        rise   = match && !m_mprev;
        old_idx = m_idx;

        m_inc = (m_idx != 0) && !m_ring && up_act;
        m_dec = (m_idx != 0) && !m_ring && dn_act;

        n_idx = m_idx;
        n_armed = m_armed;
        n_idle = m_idle;
        if (!m_ring && me) begin
            n_idx = (m_idx + 1) % 5;
            if (n_idx == 3) n_armed = 1;
        end else if (m_idx != 0 && tick && !any && m_idle + 1 == IT) begin
            n_idx = 0;
        end
        if (m_idx == 0 || any) n_idle = 0;
        else if (tick) n_idle = (m_idle + 1 == IT) ? 0 : m_idle + 1;
        if (m_idx == 0 && !m_ring && up_act) n_armed = !m_armed;

        if (m_idx == 0 && !m_ring && up_act && m_armed) begin
            m_ring = 0; m_ring_t = 0; m_snz_on = 0; m_snz_t = 0;
        end else if (m_ring) begin
            if (me || up_act) begin
                m_ring = 0; m_ring_t = 0;
            end else if (dn_act) begin
                m_ring = 0; m_ring_t = 0; m_snz_on = 1; m_snz_t = 0;
            end else if (tick) begin
                m_ring_t++;
                if (m_ring_t == RT) begin m_ring = 0; m_ring_t = 0; end
            end
        end else if (m_armed && rise) begin
            m_ring = 1; m_ring_t = 0; m_snz_on = 0; m_snz_t = 0;
        end else if (m_snz_on && tick) begin
            m_snz_t++;
            if (m_snz_t == ST) begin m_ring = 1; m_ring_t = 0; m_snz_on = 0; m_snz_t = 0; end
        end

        m_idx = n_idx; m_armed = n_armed; m_idle = n_idle;
        m_phase = m_phase ^ tick;
        m_mprev = match;

        for (int b = 0; b < 3; b++) begin
            allow = (b != 0) && (old_idx != 0);
            samp  = m_s2[b];
            fire  = m_rep_on[b] && m_lvl[b] && allow && (m_cyc == m_next_rep[b]);
            if (fire) m_next_rep[b] = m_next_rep[b] + RP;
            if (!m_lvl[b] || !allow) m_rep_on[b] = 0;
            m_evt[b] = fire;
            if (samp == m_lvl[b]) begin
                m_run[b] = 0;
            end else if (m_run[b] + 1 == DB) begin
                m_lvl[b] = samp;
                m_run[b] = 0;
                if (samp) begin
                    m_evt[b] = 1; m_rep_on[b] = 1; m_next_rep[b] = m_cyc + RD;
                end
            end else begin
                m_run[b]++;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = btn[b];
        end
    endtask

    task automatic compare_all();
        logic [1:0] f;
        f = (m_idx == 0) ? 2'd0 : ((m_idx % 2 == 1) ? 2'd1 : 2'd2);
        check("field_sel",   bus.field_sel,   f);
        check("tgt_alarm",   bus.tgt_alarm,   m_idx >= 3);
        check("show_alarm",  bus.show_alarm,  m_idx >= 3);
        check("blink_mask",  bus.blink_mask,  (m_idx == 0 || !m_phase) ? 6'h00 : ((f == 2'd1) ? 6'h03 : 6'h0C));
        check("inc_pulse",   bus.inc_pulse,   m_inc);
        check("dec_pulse",   bus.dec_pulse,   m_dec);
        check("alarm_armed", bus.alarm_armed, m_armed);
        check("ring",        bus.ring,        m_ring);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        n_inc += int'(bus.inc_pulse);
        n_dec += int'(bus.dec_pulse);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int b, input int hold, input int rel);
        btn[b] = 1'b1;
        run(hold);
        btn[b] = 1'b0;
        run(rel);
    endtask

    task automatic tick_once(input int gap);
        tick = 1'b1;
        step();
        tick = 1'b0;
        run(gap);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; match = 1'b0; btn = 3'b111;

        // Reset with buttons held, then release reset while still held
        run(2);
        check("rst_field", bus.field_sel, 2'd0);
        check("rst_ring",  bus.ring, 1'b0);
        check("rst_armed", bus.alarm_armed, 1'b0);
        check("rst_blink", bus.blink_mask, 6'h00);
        rst = 1'b1;
        n_inc = 0;
        run(12);
        check("held_field", bus.field_sel, 2'd0);
        check("held_armed", bus.alarm_armed, 1'b0);
        btn = 3'b000;
        run(10);

        // Short glitch on up is rejected
        btn[1] = 1'b1; run(3); btn[1] = 1'b0; run(8);
        check("glitch_armed", bus.alarm_armed, 1'b0);

        press(0, 6, 8); check("m1_field", bus.field_sel, 2'd1); check("m1_tgt", bus.tgt_alarm, 1'b0);
        press(0, 6, 8); check("m2_field", bus.field_sel, 2'd2); check("m2_tgt", bus.tgt_alarm, 1'b0);
        press(0, 6, 8); check("m3_field", bus.field_sel, 2'd1); check("m3_tgt", bus.tgt_alarm, 1'b1);
        check("m3_armed", bus.alarm_armed, 1'b1);
        press(0, 6, 8); check("m4_field", bus.field_sel, 2'd2); check("m4_tgt", bus.tgt_alarm, 1'b1);
        press(0, 6, 8); check("m5_field", bus.field_sel, 2'd0); check("m5_show", bus.show_alarm, 1'b0);

        // SET_MIN: long hold gives one press plus three repeats
        press(0, 6, 8); press(0, 6, 8);
        n_inc = 0;
        press(1, 31, 12);
        check("repeat_count", n_inc, 4);
        check("repeat_field", bus.field_sel, 2'd2);
        n_inc = 0; n_dec = 0;
        btn[1] = 1'b1; btn[2] = 1'b1; run(8); btn = 3'b000; run(10);
        check("both_inc", n_inc, 0);
        check("both_dec", n_dec, 0);

        // SET_HOUR idle timeout with blink
        press(0, 6, 8); press(0, 6, 8); press(0, 6, 8);
        press(0, 6, 8);
        check("sh_field", bus.field_sel, 2'd1);
        tick_once(5); check("blink1", bus.blink_mask, 6'h03);
        tick_once(5); check("blink2", bus.blink_mask, 6'h00);
        check("pre_to_field", bus.field_sel, 2'd1);
        tick_once(5); check("timeout_field", bus.field_sel, 2'd0);

        // Ring, snooze, re-ring, ring timeout
        match = 1'b1; step();
        check("ring_on", bus.ring, 1'b1);
        n_dec = 0;
        press(2, 8, 8);
        check("snooze_ring", bus.ring, 1'b0);
        check("snooze_dec", n_dec, 0);
        tick_once(3); check("snz1_ring", bus.ring, 1'b0);
        tick_once(3); check("snz2_ring", bus.ring, 1'b1);
        tick_once(3); tick_once(3); tick_once(3);
        check("rt3_ring", bus.ring, 1'b1);
        tick_once(3); check("rt4_ring", bus.ring, 1'b0);
        match = 1'b0; run(3);

        // Disarm, no ring on match, re-arm without strobe
        press(1, 6, 8);
        check("disarm", bus.alarm_armed, 1'b0);
        match = 1'b1; run(4);
        check("no_ring", bus.ring, 1'b0);
        match = 1'b0; run(2);
        n_inc = 0;
        press(1, 6, 8);
        check("rearm", bus.alarm_armed, 1'b1);
        check("rearm_inc", n_inc, 0);

        // Randomized traffic with a reset in the middle
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    btn[b] = ($urandom_range(0, 2) == 0);
                    hold_left[b] = $urandom_range(1, 30);
                end
                hold_left[b]--;
            end
            tick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) match = ~match;
            rst = !(c >= 1500 && c < 1502);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- User-interface controller for the digital clock/alarm datapath.
- Debounces the mode/up/down buttons and generates auto-repeat.
- Sequences the set-mode state machine (time hour/min, alarm hour/min) and issues single-cycle inc/dec strobes to the timekeeping datapath.
- Owns alarm arming, ringing, snooze and timeout; drives display blink and alarm-view selection.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable clk samples required to accept a button level change
REPEAT_DELAY, 25000000, clk cycles a button is held before auto-repeat starts
REPEAT_PERIOD, 5000000, clk cycles between auto-repeat strobes
IDLE_TIMEOUT, 30, tick_1s pulses with no button press before a SET state returns to RUN
RING_TIMEOUT, 60, tick_1s pulses of ringing before auto-stop
SNOOZE_TICKS, 300, tick_1s pulses from snooze until re-ring

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (0 = reset)
tick_1s  in  1  one-clk pulse per second from timekeeper
btn_mode  in  1  raw button, active high, asynchronous
btn_up  in  1  raw button, active high, asynchronous
btn_down  in  1  raw button, active high, asynchronous
alarm_match  in  1  level: current hour:min equals alarm hour:min
field_sel  out  2  0 none, 1 hour, 2 minute
tgt_alarm  out  1  1: strobes address alarm registers; 0: time registers
inc_pulse  out  1  one-clk increment strobe for the selected field
dec_pulse  out  1  one-clk decrement strobe for the selected field
show_alarm  out  1  display mux selects alarm value
blink_mask  out  6  digit blank mask, bit0 = hour tens … bit5 = sec units
alarm_armed  out  1  alarm enabled
ring  out  1  buzzer enable

Behaviour:
- Reset (rst=0 at posedge clk): state RUN. All outputs 0. Debounce, repeat, timeout, ring and snooze counters 0. blink phase 0.
- Input conditioning: 2-flop synchronizer per button.
  - Debounced level changes only after DEBOUNCE_CYCLES identical consecutive synced samples.
  - Press event = debounced 0→1, one cycle.
- Auto-repeat applies to up/down only, and only in SET states.
  - Held REPEAT_DELAY cycles after the press → extra press event, then one every REPEAT_PERIOD while held.
  - Release clears the repeat counter.
- Priority within one cycle: mode > up/down. up and down together → neither acts.
- States: RUN, SET_HOUR, SET_MIN, SET_AL_HOUR, SET_AL_MIN.
  - A mode press advances through the states in that order; SET_AL_MIN → RUN.
  - field_sel: hour states 1, minute states 2, RUN 0.
  - tgt_alarm and show_alarm = 1 in SET_AL_* only.
- Strobes: in SET states, up event → inc_pulse; down event → dec_pulse. Asserted the cycle after the event, exactly one cycle. Never asserted in RUN.
- Wrap-around (23→0, 59→0, 0→23, 0→59) is the datapath's job; this block only strobes.
- Idle timeout: a counter advances on tick_1s in SET states and clears on any press event.
  - Reaching IDLE_TIMEOUT → RUN on that tick.
- RUN: up press toggles alarm_armed. Down press while not ringing → no action.
  - Entering SET_AL_HOUR sets alarm_armed=1.
- Blink: phase toggles on every tick_1s.
  - blink_mask = 6'b000011 (hour states) or 6'b001100 (minute states) when phase=1; 0 otherwise and in RUN.
- Ringing:
  - ring sets on the rising edge of alarm_match when alarm_armed=1, in any state. Edge detection uses a registered copy of alarm_match, so a level held for a minute rings once.
  - While ring=1, any press event is consumed (no FSM or strobe action).
    - Mode or up press → ring=0.
    - Down press → ring=0 and the snooze counter starts.
  - Snooze reaching SNOOZE_TICKS → ring=1, even if alarm_match has fallen.
  - ring clears after RING_TIMEOUT ticks.
  - Clearing alarm_armed cancels both ring and snooze.
- Reset mid-operation: returns to RUN with ring=0; no strobe is emitted in the reset cycle.

Decomposition:
- Shared package: state encoding localparams, field_sel codes (FIELD_NONE/HOUR/MIN), blink mask constants.
- One sub-module, btn_conditioner: synchronizer, debounce, press-event and optional auto-repeat, parameterized by DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD.
  - Instantiated three times; repeat is disabled for mode.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, IDLE_TIMEOUT=3, RING_TIMEOUT=4, SNOOZE_TICKS=2):
- rst=0 for 2 cycles with all buttons high → all outputs 0, state RUN; release rst, buttons remain held → no press event until they are released and re-pressed.
- btn_up glitch of 3 cycles → no effect. Four mode presses → field_sel 1,2,1,2 with tgt_alarm 0,0,1,1; fifth press → RUN with field_sel 0.
- SET_MIN, hold btn_up 31 stable cycles → inc_pulse once after debounce, then at +20, +25, +30 (4 total); up+down pressed together → no strobe.
- SET_HOUR, no presses for 3 tick_1s → RUN on the 3rd tick; blink_mask alternates 000011/000000 per tick before that.
- alarm_armed=1, alarm_match rises → ring=1 next cycle; down press → ring=0, no dec_pulse; 2 ticks later → ring=1; 4 more ticks → ring=0.
- alarm_armed=0 with alarm_match rising → ring stays 0; in RUN, up press → alarm_armed=1, inc_pulse stays 0.
